// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with a combinational logic/arith/shift path plus an
//   iterative unsigned multiply/divide unit that writes the HI/LO registers.
// Latency: Y/zero/blez_out are combinational; MULTU/DIVU take WIDTH cycles,
//   divide by zero takes 1 cycle.
// Backpressure: start is accepted only when not busy; start while busy is
//   dropped, so the controller must stall on busy.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   A, B, shamt, F    operands, shift amount, combinational function select
//   md_op, start      00 none, 01 MULTU, 10 DIVU, 11 reserved; launch strobe
//   Y, zero, blez_out combinational result, Y==0, A<=0 (signed)
//   busy, done        operation in flight; one-cycle pulse after hi/lo update
//   hi, lo            result registers (product high/low, remainder/quotient)
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       F,
  input  logic [1:0]       md_op,
  input  logic             start,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             blez_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // ---------------- combinational result path ----------------
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_sum;

  assign w_bb  = F[2] ? ~B : B;
  // F[2] doubles as the carry-in, so SUB is A + ~B + 1.
  assign w_sum = A + w_bb + {{(WIDTH-1){1'b0}}, F[2]};

  always_comb begin
    Y = '0;
    case (F[1:0])
      2'b00: Y = A & w_bb;
      2'b01: Y = F[2] ? (B << shamt) : (A | w_bb);
      2'b10: begin
        case (F[3:2])
          2'b10:   Y = B >> shamt;
          2'b11:   Y = $unsigned($signed(B) >>> shamt);
          default: Y = w_sum;
        endcase
      end
      // SLT by sign of the sum only; signed overflow is deliberately not fixed up.
      default: Y = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1]};
    endcase
  end

  assign zero     = (Y == '0);
  assign blez_out = A[WIDTH-1] | (A == '0);

  // ---------------- multiply / divide unit ----------------
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [SHW-1:0]     r_count, w_count_nxt;
  // acc: MUL = {partial product, remaining multiplier bits};
  //      DIV = {partial remainder, remaining dividend / quotient bits}
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;   // multiplicand for MUL
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;

  logic               w_launch;
  logic               w_last;
  logic [WIDTH:0]     w_mul_add;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_step;

  // Shift-add: add the multiplicand into the top half when the current
  // multiplier bit is set, then shift the whole accumulator right, keeping the carry.
  assign w_mul_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_divisor};
  assign w_mul_step = r_acc[0] ? {w_mul_add, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide: the remainder stays below the divisor, so the shifted
  // remainder needs one extra bit and the difference always fits in WIDTH bits.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_divisor});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_divisor;
  assign w_div_step = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_last   = (r_count == LAST);
  assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE))
                    && ((md_op == 2'b01) || (md_op == 2'b10));

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_acc_nxt     = r_acc;
    w_divisor_nxt = r_divisor;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch) begin
          w_state_nxt   = (md_op == 2'b01) ? S_MUL : S_DIV;
          w_count_nxt   = '0;
          w_acc_nxt     = {{WIDTH{1'b0}}, A};
          w_divisor_nxt = B;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        w_acc_nxt   = w_mul_step;
        w_count_nxt = r_count + 1'b1;
        if (w_last) begin
          w_hi_nxt    = w_mul_step[2*WIDTH-1:WIDTH];
          w_lo_nxt    = w_mul_step[WIDTH-1:0];
          w_state_nxt = S_DONE;
        end
      end
      S_DIV: begin
        if (r_divisor == '0) begin
          // Divide by zero: finish at once, quotient saturated, dividend as remainder.
          w_hi_nxt    = r_acc[WIDTH-1:0];
          w_lo_nxt    = '1;
          w_state_nxt = S_DONE;
        end else begin
          w_acc_nxt   = w_div_step;
          w_count_nxt = r_count + 1'b1;
          if (w_last) begin
            w_hi_nxt    = w_div_step[2*WIDTH-1:WIDTH];
            w_lo_nxt    = w_div_step[WIDTH-1:0];
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_acc     <= w_acc_nxt;
      r_divisor <= w_divisor_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign busy = (r_state == S_MUL) || (r_state == S_DIV);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: self-checking bench for alu_md (WIDTH=32).
// Combinational path from a vector table; multiply/divide results via a
// scoreboard queue popped on every done pulse.
module tb_alu_md;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic [3:0]  F;
  logic [1:0]  md_op;
  logic        start;
  logic [31:0] Y, hi, lo;
  logic        zero, blez_out, busy, done;

  alu_md #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .shamt(shamt), .F(F),
    .md_op(md_op), .start(start), .Y(Y), .zero(zero), .blez_out(blez_out),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] q[$];
  logic [63:0] last_res = 64'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (op == 2'b01) return {32'h0, a} * {32'h0, b};
    if (b == 32'h0)  return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 required no pending op");
      end else begin
        e = q.pop_front();
        chk("md_result", {hi, lo}, e);
        last_res = e;
      end
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; md_op = op; start = 1'b1;
    q.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0; md_op = 2'b00;
    A = $urandom; B = $urandom;   // must not disturb the latched operands
    chk("busy_after_start", {63'h0, busy}, 64'h1);
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
    chk(nm, n, exp_lat);
  endtask

  task automatic idle_chk(input string nm);
    @(posedge clk); #1;
    chk(nm, {62'h0, busy, done}, 64'h0);
    chk("hilo_hold", {hi, lo}, last_res);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [3:0]  f;
    logic [31:0] y;
    logic        z;
  } vec_t;
  vec_t tv[18];

  initial begin
    logic [63:0] dummy;
    logic [1:0]  op;
    logic [31:0] ra, rb;

    tv[0]  = '{32'd5,          32'd7,          5'd0,  4'b0010, 32'd12,         1'b0};
    tv[1]  = '{32'd5,          32'd7,          5'd0,  4'b0110, 32'hFFFF_FFFE,  1'b0};
    tv[2]  = '{32'd5,          32'd7,          5'd0,  4'b0111, 32'd1,          1'b0};
    tv[3]  = '{32'd7,          32'd7,          5'd0,  4'b0110, 32'd0,          1'b1};
    tv[4]  = '{32'hF0F0_1234,  32'h0FF0_FF00,  5'd0,  4'b0000, 32'h00F0_1200,  1'b0};
    tv[5]  = '{32'hF0F0_1234,  32'h0FF0_FF00,  5'd0,  4'b0001, 32'hFFF0_FF34,  1'b0};
    tv[6]  = '{32'hF0F0_1234,  32'h0FF0_FF00,  5'd0,  4'b0100, 32'hF000_0034,  1'b0};
    tv[7]  = '{32'h8000_0000,  32'd1,          5'd0,  4'b0111, 32'd0,          1'b1};
    tv[8]  = '{32'd0,          32'd1,          5'd31, 4'b0101, 32'h8000_0000,  1'b0};
    tv[9]  = '{32'd0,          32'd1,          5'd31, 4'b1101, 32'h8000_0000,  1'b0};
    tv[10] = '{32'd0,          32'h8000_0000,  5'd4,  4'b1010, 32'h0800_0000,  1'b0};
    tv[11] = '{32'd0,          32'h8000_0000,  5'd4,  4'b1110, 32'hF800_0000,  1'b0};
    tv[12] = '{32'd0,          32'h4000_0000,  5'd4,  4'b1110, 32'h0400_0000,  1'b0};
    tv[13] = '{32'd3,          32'd5,          5'd0,  4'b0011, 32'd0,          1'b1};
    tv[14] = '{32'd0,          32'd0,          5'd0,  4'b0010, 32'd0,          1'b1};
    tv[15] = '{32'h12,         32'h34,         5'd0,  4'b1001, 32'h36,         1'b0};
    tv[16] = '{32'h8000_0000,  32'h8000_0000,  5'd0,  4'b1110, 32'h8000_0000,  1'b0};
    tv[17] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  5'd0,  4'b1100, 32'd0,          1'b1};

    reset = 1'b1; A = 0; B = 0; shamt = 0; F = 0; md_op = 0; start = 0;
    @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'h0);
    @(negedge clk);
    reset = 1'b0;

    // Combinational path
    foreach (tv[i]) begin
      @(negedge clk);
      A = tv[i].a; B = tv[i].b; shamt = tv[i].sh; F = tv[i].f;
      #1;
      chk($sformatf("Y[%0d]", i), {32'h0, Y}, {32'h0, tv[i].y});
      chk($sformatf("zero[%0d]", i), {63'h0, zero}, {63'h0, tv[i].z});
      chk($sformatf("blez[%0d]", i), {63'h0, blez_out},
          {63'h0, (tv[i].a[31] | (tv[i].a == 32'h0))});
    end

    // Reserved / none md_op with start are ignored
    @(negedge clk); start = 1'b1; md_op = 2'b11;
    @(posedge clk); #1;
    chk("ignore_op11", {62'h0, busy, done}, 64'h0);
    md_op = 2'b00;
    @(posedge clk); #1;
    chk("ignore_op00", {62'h0, busy, done}, 64'h0);
    start = 1'b0;

    // MULTU max * max, operands scrambled while busy
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_latency", 32);
    idle_chk("mul_done_pulse");

    // DIVU 100 / 7
    launch(2'b10, 32'd100, 32'd7);
    wait_done("div_latency", 32);
    idle_chk("div_done_pulse");

    // Divide by zero
    launch(2'b10, 32'h1234, 32'd0);
    wait_done("div0_latency", 1);
    idle_chk("div0_done_pulse");

    // start at cycle 10 of a multiply is ignored
    launch(2'b01, 32'hDEAD_BEEF, 32'h0001_2345);
    repeat (9) @(posedge clk);
    @(negedge clk); start = 1'b1; md_op = 2'b10; A = 32'd9; B = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; md_op = 2'b00;
    chk("start_while_busy", {62'h0, busy, done}, 64'h2);
    wait_done("mul_after_ignored_start", 22);

    // Back-to-back: divide launched in the done cycle
    launch(2'b10, 32'd100, 32'd7);
    chk("b2b_done_cleared", {63'h0, done}, 64'h0);
    wait_done("b2b_div_latency", 32);
    idle_chk("b2b_done_pulse");

    // Random operations
    for (int i = 0; i < 4; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 300)) : $urandom;
      launch(op, ra, rb);
      wait_done($sformatf("rand_latency[%0d]", i), 32);
      idle_chk($sformatf("rand_idle[%0d]", i));
    end

    // Asynchronous reset in the middle of a divide
    launch(2'b10, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_div", {busy, done, hi, lo}, 66'h0);
    dummy = q.pop_back();
    last_res = 64'h0;
    @(negedge clk); reset = 1'b0;
    idle_chk("after_reset");

    // Fresh multiply after reset
    launch(2'b01, 32'd3, 32'd4);
    wait_done("mul_3x4_latency", 32);
    idle_chk("mul_3x4_idle");

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish by 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational AND/OR/ADD/SUB/SLT/SLL/SRL result path, generalised to WIDTH bits, and adds SRA.
- Adds an iterative unsigned multiply/divide unit with a start/busy/done handshake and HI/LO result registers.
- Sits in the execute stage; the controller stalls on busy.

Parameters:
- WIDTH, 32, datapath width in bits (>=4).
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt/imm)
- shamt  input  SHW  shift amount
- F  input  4  combinational function select
- md_op  input  2  00 none, 01 MULTU, 10 DIVU, 11 reserved
- start  input  1  launch md_op with current A, B
- Y  output  WIDTH  combinational result
- zero  output  1  Y == 0
- blez_out  output  1  A[WIDTH-1] | (A == 0)
- busy  output  1  multiply/divide in progress
- done  output  1  one-cycle pulse: hi/lo just updated
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- **Combinational path** (no latency, independent of the state machine):
  - BB = F[2] ? ~B : B
  - Sum = A + BB + F[2], WIDTH bits; carry discarded
- **F decode:**
  - x000 → A & BB
  - x001 → A | BB
  - 0101, 1101 → B << shamt
  - 0010 → Sum (ADD)
  - 0110 → Sum (SUB)
  - 1010 → B >> shamt (logical)
  - 1110 → B >>> shamt (arithmetic, sign = B[WIDTH-1])
  - x011, x111 → {0…, Sum[WIDTH-1]} (SLT by sign; overflow not corrected)
- zero and blez_out are pure functions of Y and A.
- **States:** IDLE, MUL, DIV, DONE. Registers: state, count, acc (2*WIDTH), divisor, hi, lo.
- **Reset (async):** state=IDLE, hi=0, lo=0, count=0, busy=0, done=0. Reset mid-operation aborts the operation; no partial result is written.
- **Launch:**
  - start accepted in IDLE or DONE only.
  - md_op 01 → MUL; md_op 10 → DIV; md_op 00 or 11 → ignored (stay or return to IDLE).
  - A, B are latched at the accepting edge; later changes to A, B have no effect.
- **start while busy:** ignored; the operation in flight is unaffected.
- **MUL:**
  - Unsigned shift-add, one multiplier bit per cycle, WIDTH cycles.
  - After the WIDTH-th iteration edge: {hi, lo} = A*B (full 2*WIDTH product); state → DONE.
- **DIV:**
  - Restoring divide, one quotient bit per cycle, WIDTH cycles.
  - On completion: lo = quotient, hi = remainder; state → DONE.
- **Divide by zero:**
  - Latched B == 0 → DIV goes to DONE after 1 cycle.
  - lo = all ones, hi = latched A.
- **Timing:** if start is accepted at edge t:
  - busy = 1 from after edge t until edge t+WIDTH (t+1 for divide by zero).
  - hi/lo update at that same edge; done = 1 for the following cycle only.
  - DONE → IDLE on the next edge unless a new start is accepted there. Back-to-back operations are legal: done for op1 and busy for op2 coincide for one cycle.
- busy = (state == MUL || state == DIV); done = (state == DONE).
- hi/lo hold their value between operations and are never modified by the combinational path.

Test Plan:
- **Combinational sweep** (WIDTH=32):
  - A=5, B=7: F=0010 → Y=12; F=0110 → Y=0xFFFFFFFE, zero=0; F=0111 → Y=1.
  - A=7, B=7, F=0110 → Y=0, zero=1.
- **Shifts:**
  - B=1, shamt=31, F=0101 → Y=0x80000000.
  - B=0x80000000, shamt=4: F=1010 → Y=0x08000000; F=1110 → Y=0xF8000000.
- **MULTU:**
  - A=B=0xFFFFFFFF, start pulse → busy for 32 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
  - Changing A, B during busy does not alter the result.
- **DIVU:**
  - A=100, B=7 → done after 32 cycles; lo=14, hi=2.
  - A=0x1234, B=0 → done after 1 cycle; lo=0xFFFFFFFF, hi=0x1234.
- **Handshake:**
  - start asserted again at cycle 10 of a multiply → ignored.
  - start with md_op=10 during the done cycle → new divide accepted; busy is set the next cycle.
- **Reset:**
  - reset asserted at cycle 15 of a divide (asynchronously, between edges) → busy=0, done=0, hi=lo=0 immediately.
  - After reset release, a fresh MULTU 3*4 → lo=12, hi=0.
